// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle core sequencer: FSM states, trap causes and access sizes.
package core_pkg;

  typedef enum logic [6:0] {
    StIdle      = 7'b000_0001,
    StFetch     = 7'b000_0010,
    StDecode    = 7'b000_0100,
    StExecute   = 7'b000_1000,
    StMemory    = 7'b001_0000,
    StWriteback = 7'b010_0000,
    StTrap      = 7'b100_0000
  } state_e;

  localparam logic [1:0] CauseIllegal   = 2'd0;
  localparam logic [1:0] CauseLMisalign = 2'd1;
  localparam logic [1:0] CauseSMisalign = 2'd2;

  localparam logic [1:0] SizeByte  = 2'd0;
  localparam logic [1:0] SizeHalf  = 2'd1;
  localparam logic [1:0] SizeWord  = 2'd2;
  localparam logic [1:0] SizeDword = 2'd3;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic misaligned(input logic [2:0] addr, input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SizeByte: mask = 3'b000;
      SizeHalf: mask = 3'b001;
      SizeWord: mask = 3'b011;
      default:  mask = 3'b111;
    endcase
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/core_lsu_lane.sv
// Byte-lane steering for the data port: byte enables, store replication and load extract/extend.
module core_lsu_lane import core_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]                size_i,
  input  logic                      unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0] lane_i,
  input  logic [XLEN-1:0]           store_data_i,
  input  logic [XLEN-1:0]           load_raw_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           load_data_o
);

  localparam int unsigned NumBytes = XLEN / 8;

  logic [NumBytes-1:0] size_mask;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     ext_mask;
  logic                sign_bit;

  always_comb begin
    shifted   = load_raw_i >> {lane_i, 3'b000};
    size_mask = '1;
    wdata_o   = store_data_i;
    ext_mask  = '1;
    sign_bit  = shifted[XLEN-1];
    case (size_i)
      SizeByte: begin
        size_mask = NumBytes'(8'h01);
        wdata_o   = {NumBytes{store_data_i[7:0]}};
        ext_mask  = XLEN'(8'hFF);
        sign_bit  = shifted[7];
      end
      SizeHalf: begin
        size_mask = NumBytes'(8'h03);
        wdata_o   = {(NumBytes / 2){store_data_i[15:0]}};
        ext_mask  = XLEN'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      SizeWord: begin
        size_mask = NumBytes'(8'h0F);
        wdata_o   = {(NumBytes / 4){store_data_i[31:0]}};
        ext_mask  = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: ;
    endcase
    be_o        = size_mask << lane_i;
    load_data_o = shifted & ext_mask;
    if (!unsigned_i && sign_bit) load_data_o = load_data_o | ~ext_mask;
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle in-order core sequencer: fetch, decode, execute, memory and writeback with sticky traps.
module core_seq import core_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              I_REQ,
  output logic [XLEN-1:0]   I_ADDR,
  input  logic              I_ACK,
  input  logic [31:0]       I_RDATA,
  output logic [31:0]       INST,
  input  logic              DEC_LOAD,
  input  logic              DEC_STORE,
  input  logic              DEC_BRANCH,
  input  logic              DEC_JAL,
  input  logic              DEC_JALR,
  input  logic              DEC_RD_WE,
  input  logic              DEC_ILLEGAL,
  input  logic [2:0]        DEC_FUNCT3,
  input  logic              BR_TAKEN,
  input  logic [XLEN-1:0]   TGT_PC,
  input  logic [XLEN-1:0]   TGT_JALR,
  input  logic [XLEN-1:0]   ALU_RESULT,
  input  logic [XLEN-1:0]   RS2_DATA,
  output logic              D_REQ,
  output logic              D_WE,
  output logic [XLEN-1:0]   D_ADDR,
  output logic [XLEN-1:0]   D_WDATA,
  output logic [XLEN/8-1:0] D_BE,
  input  logic              D_ACK,
  input  logic [XLEN-1:0]   D_RDATA,
  output logic              RF_WE,
  output logic [XLEN-1:0]   RF_WDATA,
  output logic [XLEN-1:0]   PC,
  output logic              TRAP,
  output logic [1:0]        TRAP_CAUSE,
  output logic [XLEN-1:0]   TRAP_PC
);

  localparam int unsigned LaneW = $clog2(XLEN / 8);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, alu_q, rs2_q, tgt_pc_q, tgt_jalr_q, ld_q, trap_pc_q;
  logic [31:0]     inst_q;
  logic [2:0]      funct3_q;
  logic [1:0]      trap_cause_q;
  logic            load_q, store_q, branch_q, jal_q, jalr_q, rd_we_q, br_taken_q, trap_q;

  logic            mem_op, bad_size, misalign, exec_trap;
  logic [1:0]      exec_cause;
  logic [XLEN-1:0] pc_plus4, pc_next;
  logic [XLEN/8-1:0] lane_be;
  logic [XLEN-1:0] lane_wdata, lane_load;

  // Exit checks run on the live decode inputs during EXECUTE.
  assign mem_op    = DEC_LOAD | DEC_STORE;
  assign bad_size  = mem_op && (DEC_FUNCT3[1:0] == SizeDword) && ((XLEN == 32) || DEC_FUNCT3[2]);
  assign misalign  = mem_op && misaligned(ALU_RESULT[2:0], DEC_FUNCT3[1:0]);
  assign exec_trap = DEC_ILLEGAL | bad_size | misalign;
  assign exec_cause = (DEC_ILLEGAL || bad_size) ? CauseIllegal :
                      DEC_LOAD                  ? CauseLMisalign : CauseSMisalign;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      state_d = StFetch;
      StFetch:     if (I_ACK) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute: begin
        if (exec_trap)   state_d = StTrap;
        else if (mem_op) state_d = StMemory;
        else             state_d = StWriteback;
      end
      StMemory:    if (D_ACK) state_d = StWriteback;
      StWriteback: state_d = StFetch;
      StTrap:      state_d = StTrap;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_plus4 = pc_q + XLEN'(4);
    if (jal_q || (branch_q && br_taken_q)) pc_next = tgt_pc_q;
    else if (jalr_q)                       pc_next = tgt_jalr_q;
    else                                   pc_next = pc_plus4;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      alu_q        <= '0;
      rs2_q        <= '0;
      tgt_pc_q     <= '0;
      tgt_jalr_q   <= '0;
      ld_q         <= '0;
      funct3_q     <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      branch_q     <= 1'b0;
      jal_q        <= 1'b0;
      jalr_q       <= 1'b0;
      rd_we_q      <= 1'b0;
      br_taken_q   <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
    end else begin
      if (state_q == StFetch && I_ACK) inst_q <= I_RDATA;
      if (state_q == StExecute) begin
        alu_q      <= ALU_RESULT;
        rs2_q      <= RS2_DATA;
        tgt_pc_q   <= TGT_PC;
        tgt_jalr_q <= TGT_JALR & ~XLEN'(1);
        br_taken_q <= BR_TAKEN;
        funct3_q   <= DEC_FUNCT3;
        load_q     <= DEC_LOAD;
        store_q    <= DEC_STORE;
        branch_q   <= DEC_BRANCH;
        jal_q      <= DEC_JAL;
        jalr_q     <= DEC_JALR;
        rd_we_q    <= DEC_RD_WE;
        if (exec_trap) begin
          trap_q       <= 1'b1;
          trap_cause_q <= exec_cause;
          trap_pc_q    <= pc_q;
        end
      end
      if (state_q == StMemory && D_ACK) ld_q <= lane_load;
      if (state_q == StWriteback) pc_q <= pc_next;
    end
  end

  core_lsu_lane #(
    .XLEN(XLEN)
  ) u_lane (
    .size_i      (funct3_q[1:0]),
    .unsigned_i  (funct3_q[2]),
    .lane_i      (alu_q[LaneW-1:0]),
    .store_data_i(rs2_q),
    .load_raw_i  (D_RDATA),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .load_data_o (lane_load)
  );

  assign I_REQ      = (state_q == StFetch);
  assign I_ADDR     = pc_q;
  assign INST       = inst_q;
  assign D_REQ      = (state_q == StMemory);
  assign D_WE       = D_REQ & store_q;
  assign D_ADDR     = alu_q;
  assign D_WDATA    = D_REQ ? lane_wdata : '0;
  assign D_BE       = D_REQ ? lane_be : '0;
  assign RF_WE      = (state_q == StWriteback) & rd_we_q;
  assign RF_WDATA   = (jal_q || jalr_q) ? pc_plus4 : (load_q ? ld_q : alu_q);
  assign PC         = pc_q;
  assign TRAP       = trap_q;
  assign TRAP_CAUSE = trap_cause_q;
  assign TRAP_PC    = trap_pc_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: a 32-bit instance at RESET_PC 0 and a 64-bit instance at 0x100.
module tb_core_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic        dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_rd_we, dec_illegal;
  logic        br_taken;
  logic [2:0]  dec_funct3;
  logic [31:0] i_rdata;

  logic        i_req, i_ack, d_req, d_we, d_ack, rf_we, trap;
  logic [31:0] i_addr, inst, tgt_pc, tgt_jalr, alu, rs2, d_addr, d_wdata, d_rdata;
  logic [31:0] rf_wdata, pc, trap_pc;
  logic [3:0]  d_be;
  logic [1:0]  trap_cause;

  logic        i_req_w, i_ack_w, d_req_w, d_we_w, d_ack_w, rf_we_w, trap_w;
  logic [31:0] inst_w;
  logic [63:0] i_addr_w, tgt_pc_w, tgt_jalr_w, alu_w, rs2_w, d_addr_w, d_wdata_w, d_rdata_w;
  logic [63:0] rf_wdata_w, pc_w, trap_pc_w;
  logic [7:0]  d_be_w;
  logic [1:0]  trap_cause_w;

  int checks = 0;
  int errors = 0;

  core_seq #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .I_REQ(i_req), .I_ADDR(i_addr), .I_ACK(i_ack), .I_RDATA(i_rdata),
    .INST(inst), .DEC_LOAD(dec_load), .DEC_STORE(dec_store), .DEC_BRANCH(dec_branch),
    .DEC_JAL(dec_jal), .DEC_JALR(dec_jalr), .DEC_RD_WE(dec_rd_we), .DEC_ILLEGAL(dec_illegal),
    .DEC_FUNCT3(dec_funct3), .BR_TAKEN(br_taken), .TGT_PC(tgt_pc), .TGT_JALR(tgt_jalr),
    .ALU_RESULT(alu), .RS2_DATA(rs2), .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr),
    .D_WDATA(d_wdata), .D_BE(d_be), .D_ACK(d_ack), .D_RDATA(d_rdata), .RF_WE(rf_we),
    .RF_WDATA(rf_wdata), .PC(pc), .TRAP(trap), .TRAP_CAUSE(trap_cause), .TRAP_PC(trap_pc)
  );

  core_seq #(.XLEN(64), .RESET_PC(64'h100)) dut_w (
    .CLK(CLK), .RST_N(RST_N), .I_REQ(i_req_w), .I_ADDR(i_addr_w), .I_ACK(i_ack_w),
    .I_RDATA(i_rdata), .INST(inst_w), .DEC_LOAD(dec_load), .DEC_STORE(dec_store),
    .DEC_BRANCH(dec_branch), .DEC_JAL(dec_jal), .DEC_JALR(dec_jalr), .DEC_RD_WE(dec_rd_we),
    .DEC_ILLEGAL(dec_illegal), .DEC_FUNCT3(dec_funct3), .BR_TAKEN(br_taken),
    .TGT_PC(tgt_pc_w), .TGT_JALR(tgt_jalr_w), .ALU_RESULT(alu_w), .RS2_DATA(rs2_w),
    .D_REQ(d_req_w), .D_WE(d_we_w), .D_ADDR(d_addr_w), .D_WDATA(d_wdata_w), .D_BE(d_be_w),
    .D_ACK(d_ack_w), .D_RDATA(d_rdata_w), .RF_WE(rf_we_w), .RF_WDATA(rf_wdata_w), .PC(pc_w),
    .TRAP(trap_w), .TRAP_CAUSE(trap_cause_w), .TRAP_PC(trap_pc_w)
  );

  task automatic set_dec(input logic ld, st, br, jl, jr, we, ill, input logic [2:0] f3);
    dec_load = ld; dec_store = st; dec_branch = br; dec_jal = jl; dec_jalr = jr;
    dec_rd_we = we; dec_illegal = ill; dec_funct3 = f3;
  endtask

  // Called at a FETCH negedge; returns at the DECODE negedge.
  task automatic fetch32(input logic [31:0] insn);
    i_rdata = insn; i_ack = 1'b1;
    @(negedge CLK);
    i_ack = 1'b0;
  endtask

  task automatic fetch64(input logic [31:0] insn);
    i_rdata = insn; i_ack_w = 1'b1;
    @(negedge CLK);
    i_ack_w = 1'b0;
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    @(negedge CLK);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (pc_w !== 64'h100) begin errors++; $display("FAIL reset_pc64: got %h want %h", pc_w, 64'h100); end
    checks++; if ({i_req, d_req, d_we, rf_we, i_req_w, d_req_w} !== 6'b0) begin errors++;
      $display("FAIL reset_reqs: got %b want %b", {i_req, d_req, d_we, rf_we, i_req_w, d_req_w}, 6'b0); end
    checks++; if ({trap, trap_cause, trap_pc, inst} !== 67'h0) begin errors++;
      $display("FAIL reset_trap_inst: got %h want %h", {trap, trap_cause, trap_pc, inst}, 67'h0); end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h0) begin errors++;
      $display("FAIL first_fetch: got req=%b addr=%h want req=1 addr=0", i_req, i_addr); end
    checks++; if (i_req_w !== 1'b1 || i_addr_w !== 64'h100) begin errors++;
      $display("FAIL first_fetch64: got req=%b addr=%h want req=1 addr=100", i_req_w, i_addr_w); end
  endtask

  task automatic test_xlen64;
    fetch64(32'h00B43023);
    checks++; if (inst_w !== 32'h00B43023) begin errors++; $display("FAIL sd_inst: got %h want %h", inst_w, 32'h00B43023); end
    set_dec(0, 1, 0, 0, 0, 0, 0, 3'd3); alu_w = 64'h8; rs2_w = 64'h1122334455667788;
    @(negedge CLK); @(negedge CLK);
    checks++; if ({d_req_w, d_we_w, d_be_w} !== 10'b11_1111_1111) begin errors++;
      $display("FAIL sd_be: got req=%b we=%b be=%h want 1 1 ff", d_req_w, d_we_w, d_be_w); end
    checks++; if (d_wdata_w !== 64'h1122334455667788 || d_addr_w !== 64'h8) begin errors++;
      $display("FAIL sd_data: got %h @%h want 1122334455667788 @8", d_wdata_w, d_addr_w); end
    d_ack_w = 1'b1; @(negedge CLK); d_ack_w = 1'b0;
    checks++; if (rf_we_w !== 1'b0) begin errors++; $display("FAIL sd_rfwe: got %b want 0", rf_we_w); end
    @(negedge CLK);
    checks++; if (i_addr_w !== 64'h104) begin errors++; $display("FAIL sd_next: got %h want 104", i_addr_w); end
    for (int k = 0; k < 2; k++) begin
      logic [63:0] want;
      want = (k == 0) ? 64'hFFFF_FFFF_8000_0001 : 64'h0000_0000_8000_0001;
      fetch64(32'h00442083);
      set_dec(1, 0, 0, 0, 0, 1, 0, (k == 0) ? 3'd2 : 3'd6); alu_w = 64'h4;
      @(negedge CLK); @(negedge CLK);
      checks++; if (d_be_w !== 8'hF0 || d_we_w !== 1'b0) begin errors++;
        $display("FAIL lw64_be[%0d]: got be=%h we=%b want f0 0", k, d_be_w, d_we_w); end
      d_rdata_w = 64'h8000_0001_0000_0000; d_ack_w = 1'b1;
      @(negedge CLK); d_ack_w = 1'b0;
      checks++; if (rf_we_w !== 1'b1 || rf_wdata_w !== want) begin errors++;
        $display("FAIL lw64_data[%0d]: got we=%b %h want 1 %h", k, rf_we_w, rf_wdata_w, want); end
      @(negedge CLK);
    end
    checks++; if (pc_w !== 64'h10C || {trap_w, trap_cause_w, trap_pc_w} !== 67'h0) begin errors++;
      $display("FAIL x64_end: got pc=%h trap=%b cause=%h tpc=%h want 10c 0 0 0", pc_w, trap_w,
               trap_cause_w, trap_pc_w); end
  endtask

  task automatic test_addi;
    fetch32(32'h00500093);
    checks++; if (inst !== 32'h00500093 || i_req !== 1'b0) begin errors++;
      $display("FAIL addi_decode: got inst=%h req=%b want 00500093 0", inst, i_req); end
    set_dec(0, 0, 0, 0, 0, 1, 0, 3'd0); alu = 32'h5;
    @(negedge CLK); @(negedge CLK);
    alu = 32'hDEAD_BEEF;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h5) begin errors++;
      $display("FAIL addi_wb: got we=%b data=%h want 1 5", rf_we, rf_wdata); end
    @(negedge CLK);
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h4 || rf_we !== 1'b0) begin errors++;
      $display("FAIL addi_next: got req=%b addr=%h we=%b want 1 4 0", i_req, i_addr, rf_we); end
  endtask

  task automatic test_branch_wait;
    fetch32(32'h04000063);
    set_dec(0, 0, 1, 0, 0, 0, 0, 3'd0); br_taken = 1'b1; tgt_pc = 32'h40;
    @(negedge CLK); @(negedge CLK);
    tgt_pc = 32'h0; br_taken = 1'b0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL beq_rfwe: got %b want 0", rf_we); end
    @(negedge CLK);
    d_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (i_req !== 1'b1 || i_addr !== 32'h40) begin errors++;
        $display("FAIL beq_wait[%0d]: got req=%b addr=%h want 1 40", k, i_req, i_addr); end
      if (k < 3) @(negedge CLK);
    end
    d_ack = 1'b0;
  endtask

  task automatic test_jumps;
    fetch32(32'h0C0000EF);
    set_dec(0, 0, 0, 1, 0, 1, 0, 3'd0); tgt_pc = 32'h100; alu = 32'h7;
    @(negedge CLK); @(negedge CLK);
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'h44) begin errors++;
      $display("FAIL jal_link: got we=%b data=%h want 1 44", rf_we, rf_wdata); end
    @(negedge CLK);
    checks++; if (i_addr !== 32'h100) begin errors++; $display("FAIL jal_target: got %h want 100", i_addr); end
    fetch32(32'h000080E7);
    set_dec(0, 0, 0, 0, 1, 1, 0, 3'd0); tgt_jalr = 32'h201;
    @(negedge CLK); @(negedge CLK);
    checks++; if (rf_wdata !== 32'h104) begin errors++; $display("FAIL jalr_link: got %h want 104", rf_wdata); end
    @(negedge CLK);
    checks++; if (i_addr !== 32'h200) begin errors++; $display("FAIL jalr_target: got %h want 200", i_addr); end
    fetch32(32'h00000063);
    set_dec(0, 0, 1, 0, 0, 0, 0, 3'd0); br_taken = 1'b0; tgt_pc = 32'h999;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    checks++; if (i_addr !== 32'h204) begin errors++; $display("FAIL bnt_next: got %h want 204", i_addr); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s   [3] = '{3'd0, 3'd4, 3'd1};
    logic [31:0] addrs [3] = '{32'h1003, 32'h1003, 32'h1002};
    logic [3:0]  bes   [3] = '{4'b1000, 4'b1000, 4'b1100};
    logic [31:0] wants [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012};
    for (int k = 0; k < 3; k++) begin
      fetch32(32'h00300083);
      set_dec(1, 0, 0, 0, 0, 1, 0, f3s[k]); alu = addrs[k];
      @(negedge CLK); @(negedge CLK);
      alu = 32'h0;
      checks++; if (d_req !== 1'b1 || d_we !== 1'b0 || d_addr !== addrs[k] || d_be !== bes[k]) begin
        errors++; $display("FAIL load_req[%0d]: got req=%b we=%b addr=%h be=%b want 1 0 %h %b", k,
                           d_req, d_we, d_addr, d_be, addrs[k], bes[k]); end
      @(negedge CLK);
      checks++; if (d_req !== 1'b1) begin errors++; $display("FAIL load_wait[%0d]: got %b want 1", k, d_req); end
      d_rdata = 32'h8012_3456; d_ack = 1'b1;
      @(negedge CLK); d_ack = 1'b0;
      checks++; if (rf_we !== 1'b1 || rf_wdata !== wants[k]) begin errors++;
        $display("FAIL load_data[%0d]: got we=%b %h want 1 %h", k, rf_we, rf_wdata, wants[k]); end
      @(negedge CLK);
    end
    checks++; if (pc !== 32'h210) begin errors++; $display("FAIL load_pc: got %h want 210", pc); end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s   [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] addrs [3] = '{32'h1001, 32'h1002, 32'h1000};
    logic [3:0]  bes   [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wants [3] = '{32'hA5A5_A5A5, 32'h56A5_56A5, 32'h1234_56A5};
    for (int k = 0; k < 3; k++) begin
      fetch32(32'h00000023);
      set_dec(0, 1, 0, 0, 0, 0, 0, f3s[k]); alu = addrs[k]; rs2 = 32'h1234_56A5;
      @(negedge CLK); @(negedge CLK);
      rs2 = 32'h0;
      checks++; if (d_we !== 1'b1 || d_be !== bes[k] || d_wdata !== wants[k]) begin errors++;
        $display("FAIL store[%0d]: got we=%b be=%b data=%h want 1 %b %h", k, d_we, d_be, d_wdata,
                 bes[k], wants[k]); end
      d_ack = 1'b1;
      @(negedge CLK); d_ack = 1'b0;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL store_rfwe[%0d]: got %b want 0", k, rf_we); end
      @(negedge CLK);
    end
  endtask

  task automatic test_store_misalign;
    logic seen;
    fetch32(32'h00101023);
    set_dec(0, 1, 0, 0, 0, 0, 0, 3'd1); alu = 32'h2001;
    @(negedge CLK); @(negedge CLK);
    checks++; if (trap !== 1'b1 || trap_cause !== 2'd2 || trap_pc !== 32'h21C) begin errors++;
      $display("FAIL sh_trap: got %b cause=%0d pc=%h want 1 2 21c", trap, trap_cause, trap_pc); end
    seen = d_req | i_req | rf_we;
    i_ack = 1'b1; d_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      seen = seen | d_req | i_req | rf_we;
    end
    i_ack = 1'b0; d_ack = 1'b0;
    checks++; if (seen !== 1'b0 || pc !== 32'h21C || trap !== 1'b1) begin errors++;
      $display("FAIL trap_hold: got reqs=%b pc=%h trap=%b want 0 21c 1", seen, pc, trap); end
  endtask

  task automatic test_traps;
    logic        lds    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        ills   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3s    [4] = '{3'd0, 3'd2, 3'd3, 3'd5};
    logic [31:0] addrs  [4] = '{32'h0, 32'h1002, 32'h1000, 32'h1001};
    logic [1:0]  causes [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      fetch32(32'h0000_0003);
      set_dec(lds[k], 0, 0, 0, 0, 1, ills[k], f3s[k]); alu = addrs[k];
      @(negedge CLK); @(negedge CLK);
      checks++; if (trap !== 1'b1 || trap_cause !== causes[k] || d_req !== 1'b0) begin errors++;
        $display("FAIL trap[%0d]: got %b cause=%0d dreq=%b want 1 %0d 0", k, trap, trap_cause,
                 d_req, causes[k]); end
    end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    fetch32(32'h0000_2003);
    set_dec(1, 0, 0, 0, 0, 1, 0, 3'd2); alu = 32'h1000;
    @(negedge CLK); @(negedge CLK);
    checks++; if (d_req !== 1'b1) begin errors++; $display("FAIL inflight_req: got %b want 1", d_req); end
    d_rdata = 32'h1111_2222; d_ack = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    checks++; if (d_req !== 1'b0 || pc !== 32'h0 || inst !== 32'h0) begin errors++;
      $display("FAIL async_reset: got dreq=%b pc=%h inst=%h want 0 0 0", d_req, pc, inst); end
    @(negedge CLK);
    d_ack = 1'b0; RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h0 || rf_we !== 1'b0) begin errors++;
      $display("FAIL restart: got req=%b addr=%h we=%b want 1 0 0", i_req, i_addr, rf_we); end
  endtask

  initial begin
    RST_N = 1'b0; i_ack = 1'b0; d_ack = 1'b0; i_ack_w = 1'b0; d_ack_w = 1'b0;
    i_rdata = '0; br_taken = 1'b0; tgt_pc = '0; tgt_jalr = '0; alu = '0; rs2 = '0; d_rdata = '0;
    tgt_pc_w = '0; tgt_jalr_w = '0; alu_w = '0; rs2_w = '0; d_rdata_w = '0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 3'd0);
    test_reset();
    test_xlen64();
    test_addi();
    test_branch_wait();
    test_jumps();
    test_loads();
    test_stores();
    test_store_misalign();
    test_traps();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath and address width; legal values 32 and 64.
REQ-002 Parameter RESET_PC, default 0, SHALL be the PC value loaded on reset.
REQ-003 Ports, name  direction  width  meaning:
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 I_REQ  out  1 / I_ADDR  out  XLEN / I_ACK  in  1 / I_RDATA  in  32: instruction fetch handshake.
REQ-007 INST  out  32: instruction latched at fetch completion, feeds the external decoder.
REQ-008 DEC_LOAD, DEC_STORE, DEC_BRANCH, DEC_JAL, DEC_JALR, DEC_RD_WE, DEC_ILLEGAL  in  1 each: decoded class of INST.
REQ-009 DEC_FUNCT3  in  3: memory access size/sign; BR_TAKEN  in  1: branch condition.
REQ-010 TGT_PC  in  XLEN: PC+imm; TGT_JALR  in  XLEN: rs1+imm; ALU_RESULT  in  XLEN: ALU result and memory address; RS2_DATA  in  XLEN: store data.
REQ-011 D_REQ  out  1 / D_WE  out  1 / D_ADDR  out  XLEN / D_WDATA  out  XLEN / D_BE  out  XLEN/8 / D_ACK  in  1 / D_RDATA  in  XLEN: data memory handshake.
REQ-012 RF_WE  out  1 / RF_WDATA  out  XLEN: register-file write port; rd index is routed externally.
REQ-013 PC  out  XLEN: architectural PC.
REQ-014 TRAP  out  1 / TRAP_CAUSE  out  2 / TRAP_PC  out  XLEN: sticky trap indication.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP, one-hot encoded.
REQ-016 IDLE SHALL go to FETCH on the first clock after reset release.
REQ-017 FETCH: I_REQ=1, I_ADDR=PC, held stable until I_ACK; on I_ACK, INST<=I_RDATA, go to DECODE; wait states unbounded.
REQ-018 DECODE SHALL last exactly one cycle, then go to EXECUTE.
REQ-019 EXECUTE SHALL latch ALU_RESULT, RS2_DATA, BR_TAKEN, TGT_PC, TGT_JALR and the DEC_* controls; the block ignores these inputs in all other states.
REQ-020 EXECUTE exit: DEC_ILLEGAL -> TRAP cause 0; misaligned load -> TRAP cause 1; misaligned store -> TRAP cause 2; legal load/store -> MEMORY; otherwise -> WRITEBACK.
REQ-021 Access size is DEC_FUNCT3[1:0]: 0=byte, 1=half, 2=word, 3=dword. The access is misaligned when any address bit below the size is set. Size 3 with XLEN=32, and unsigned size 3, SHALL be treated as illegal (cause 0).
REQ-022 MEMORY: D_REQ=1; D_WE=store; D_ADDR=latched ALU_RESULT; D_WDATA and D_BE stable until D_ACK; on D_ACK, load data captured, go to WRITEBACK.
REQ-023 D_BE SHALL be the size mask shifted left by the address lane (e.g. XLEN=32 SB at addr 0x3 -> 4'b1000; SW -> 4'b1111); D_WDATA SHALL replicate the low store bytes across all lanes.
REQ-024 Load data SHALL be the addressed lane, sign-extended when DEC_FUNCT3[2]=0 and zero-extended when DEC_FUNCT3[2]=1.
REQ-025 WRITEBACK: RF_WE=1 for exactly one cycle when latched DEC_RD_WE=1; RF_WDATA = PC+4 for JAL/JALR, extended load data for loads, latched ALU_RESULT otherwise.
REQ-026 WRITEBACK PC update: TGT_PC if JAL or (BRANCH and BR_TAKEN); TGT_JALR with bit 0 cleared if JALR; else PC+4 (wraps modulo 2^XLEN). Then go to FETCH.
REQ-027 Latency with zero-wait ACKs: ALU/branch instructions take 4 cycles FETCH-to-FETCH; loads and stores take 5.
REQ-028 TRAP SHALL be terminal until reset: TRAP=1, TRAP_PC=faulting PC, no requests issued, RF_WE=0, PC frozen.
REQ-029 I_ACK outside FETCH and D_ACK outside MEMORY SHALL be ignored.
REQ-030 D_REQ, D_WE, I_REQ and RF_WE SHALL be 0 in all states other than the ones named above.

Reset
REQ-031 RST_N low SHALL immediately force IDLE, PC=RESET_PC, INST=0, all request and write outputs 0, TRAP=0, TRAP_CAUSE=0, TRAP_PC=0, and all latched operands 0, including when a transaction is in flight; a pending ACK is dropped.

Structure
REQ-032 Shared package core_pkg SHALL hold the state encodings, trap cause codes (ILLEGAL=0, LMISALIGN=1, SMISALIGN=2) and access size codes.
REQ-033 The lane logic (D_BE, D_WDATA replication, load extract/extend) SHALL be a sub-module core_lsu_lane, parametrised by XLEN.

Verification
REQ-034 ADDI at RESET_PC=0x0, zero-wait ACKs -> RF_WE pulse in cycle 4 after the first FETCH, with RF_WDATA=ALU_RESULT; next I_ADDR=0x4.
REQ-035 XLEN=32, LB at addr 0x1003 with D_RDATA=0x80xxxxxx -> D_BE=4'b1000 and RF_WDATA=0xFFFFFF80; LBU gives 0x00000080.
REQ-036 SH at addr 0x2001 -> TRAP=1, TRAP_CAUSE=2, TRAP_PC=instruction PC, D_REQ never asserted.
REQ-037 BEQ taken with TGT_PC=0x40 and I_ACK delayed 3 cycles -> I_ADDR=0x40 held stable through all wait cycles.
REQ-038 RST_N asserted while D_REQ=1 and D_ACK is pending -> D_REQ=0 without waiting for a clock edge, and after release the fetch restarts from RESET_PC.
REQ-039 XLEN=64, SD at addr 0x8 -> D_BE=8'hFF; LW at addr 0x4 -> D_BE=8'hF0 with sign-extended upper-lane result.
